// File: rtl/and_stream_checker_if.sv
// Operand/result stream and status bundle between a test driver and the AND checker.
interface and_stream_checker_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_tests;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y_dut;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [WIDTH-1:0] ff_a;
  logic [WIDTH-1:0] ff_b;
  logic [WIDTH-1:0] ff_y;

  // Driver side: issues runs and vectors, observes status.
  modport master (
    output start, num_tests, in_valid, a, b, y_dut,
    input  busy, done, err, pass_cnt, fail_cnt, ff_a, ff_b, ff_y
  );

  // Checker side.
  modport slave (
    input  start, num_tests, in_valid, a, b, y_dut,
    output busy, done, err, pass_cnt, fail_cnt, ff_a, ff_b, ff_y
  );
endinterface

// File: rtl/and_stream_checker.sv
// Self-checking monitor for a bitwise-AND datapath: delays golden a&b by
// LATENCY cycles, compares against the DUT result and keeps run statistics.
module and_stream_checker #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic                clk,
  input logic                rst,
  and_stream_checker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_tests;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_ff_a;
  logic [WIDTH-1:0] r_ff_b;
  logic [WIDTH-1:0] r_ff_y;

  // Delay line: entry LATENCY-1 lines up with the DUT result of its vector.
  logic             r_dl_vld [LATENCY];
  logic [WIDTH-1:0] r_dl_a   [LATENCY];
  logic [WIDTH-1:0] r_dl_b   [LATENCY];
  logic [WIDTH-1:0] r_dl_exp [LATENCY];

  logic             w_accept;
  logic             w_cmp;
  logic             w_match;
  logic [CNT_W:0]   w_total;
  logic             w_run_done;

  assign w_accept   = (r_state == S_RUN) && bus.in_valid && (r_issue_cnt < r_tests);
  assign w_cmp      = (r_state == S_RUN) && r_dl_vld[LATENCY-1];
  assign w_match    = (bus.y_dut == r_dl_exp[LATENCY-1]);
  assign w_total    = {1'b0, r_pass_cnt} + {1'b0, r_fail_cnt};
  assign w_run_done = (w_total == {1'b0, r_tests});

  // Run control, delay line, comparison and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tests     <= '0;
      r_issue_cnt <= '0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ff_a      <= '0;
      r_ff_b      <= '0;
      r_ff_y      <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_dl_vld[i] <= 1'b0;
        r_dl_a[i]   <= '0;
        r_dl_b[i]   <= '0;
        r_dl_exp[i] <= '0;
      end
    end else begin
      r_dl_vld[0] <= w_accept;
      r_dl_a[0]   <= bus.a;
      r_dl_b[0]   <= bus.b;
      r_dl_exp[0] <= bus.a & bus.b;
      for (int i = 1; i < LATENCY; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_a[i]   <= r_dl_a[i-1];
        r_dl_b[i]   <= r_dl_b[i-1];
        r_dl_exp[i] <= r_dl_exp[i-1];
      end

      // Status flags trail the state by one cycle.
      r_busy <= (r_state == S_RUN);
      r_done <= (r_state == S_DONE);

      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_tests     <= bus.num_tests;
            r_issue_cnt <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_err       <= 1'b0;
            r_ff_a      <= '0;
            r_ff_b      <= '0;
            r_ff_y      <= '0;
            for (int i = 0; i < LATENCY; i++) begin
              r_dl_vld[i] <= 1'b0;
            end
            r_state <= (bus.num_tests == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
          end
          if (w_cmp) begin
            if (w_match) begin
              if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
            end else begin
              if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
              r_err <= 1'b1;
              if (!r_err) begin
                r_ff_a <= r_dl_a[LATENCY-1];
                r_ff_b <= r_dl_b[LATENCY-1];
                r_ff_y <= bus.y_dut;
              end
            end
          end
          if (w_run_done) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.pass_cnt = r_pass_cnt;
  assign bus.fail_cnt = r_fail_cnt;
  assign bus.ff_a     = r_ff_a;
  assign bus.ff_b     = r_ff_b;
  assign bus.ff_y     = r_ff_y;

endmodule

// File: tb/tb_and_stream_checker.sv
// Bench for and_stream_checker: a 2-stage AND model with injectable results,
// directed runs, and a scoreboard checked whenever done rises.
module tb_and_stream_checker;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned CNT_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  and_stream_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  and_stream_checker #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model DUT: two-stage pipeline carrying a bench-chosen result per vector.
  logic [WIDTH-1:0] y_in = '0;
  logic [WIDTH-1:0] s1 = '0;
  logic [WIDTH-1:0] s2 = '0;
  always @(posedge clk) begin
    s1 <= y_in;
    s2 <= s1;
  end
  assign bus.y_dut = s2;

  typedef struct {
    string       name;
    int unsigned pass_c;
    int unsigned fail_c;
    bit          err;
    bit          busy;
    logic [7:0]  fa;
    logic [7:0]  fb;
    logic [7:0]  fy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input int unsigned p, input int unsigned f,
                          input bit e, input logic [7:0] fa, input logic [7:0] fb,
                          input logic [7:0] fy);
    exp_t x;
    x.name = name; x.pass_c = p; x.fail_c = f; x.err = e; x.busy = 1'b0;
    x.fa = fa; x.fb = fb; x.fy = fy;
    sb.push_back(x);
  endtask

  // Monitor: on every rising done, pop the expected run result and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done && !prev_done) begin
        if (sb.size() == 0) begin
          chk("sb_has_entry", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_pass"}, 32'(bus.pass_cnt), 32'(e.pass_c));
          chk({e.name, "_fail"}, 32'(bus.fail_cnt), 32'(e.fail_c));
          chk({e.name, "_err"},  32'(bus.err),      32'(e.err));
          chk({e.name, "_busy"}, 32'(bus.busy),     32'(e.busy));
          chk({e.name, "_ff_a"}, 32'(bus.ff_a),     32'(e.fa));
          chk({e.name, "_ff_b"}, 32'(bus.ff_b),     32'(e.fb));
          chk({e.name, "_ff_y"}, 32'(bus.ff_y),     32'(e.fy));
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0; bus.num_tests = '0; bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; y_in = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_run(input logic [CNT_W-1:0] n);
    bus.start = 1'b1; bus.num_tests = n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] y);
    bus.in_valid = v; bus.a = a; bus.b = b; y_in = y;
    @(negedge clk);
    bus.in_valid = 1'b0; y_in = '0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) chk({name, "_timeout"}, 32'(bus.done), 32'd1);
    @(negedge clk);
  endtask

  task automatic send4(input logic [7:0] y2, input logic [7:0] y3, input logic [7:0] y4);
    send(1'b1, 8'hFF, 8'h0F, 8'h0F);
    send(1'b1, 8'hAA, 8'h55, y2);
    send(1'b1, 8'hF0, 8'h3C, y3);
    send(1'b1, 8'h81, 8'h81, y4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err",  32'(bus.err),  32'd0);
    chk("rst_pass", 32'(bus.pass_cnt), 32'd0);
    chk("rst_fail", 32'(bus.fail_cnt), 32'd0);

    // All-correct run with done latency check.
    push_exp("t1", 4, 0, 1'b0, 8'h00, 8'h00, 8'h00);
    start_run(16'd4);
    send4(8'h00, 8'h30, 8'h81);
    chk("t1_busy_run", 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_done_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("t1_done_lat", 32'(bus.done), 32'd1);
    @(negedge clk);

    // Single corrupted result on vector 3.
    do_reset();
    push_exp("t2", 3, 1, 1'b1, 8'hF0, 8'h3C, 8'h31);
    start_run(16'd4);
    send4(8'h00, 8'h31, 8'h81);
    wait_done("t2");

    // Two mismatches: first one must be captured.
    do_reset();
    push_exp("t3", 2, 2, 1'b1, 8'hAA, 8'h55, 8'h01);
    start_run(16'd4);
    send4(8'h01, 8'h30, 8'h00);
    wait_done("t3");

    // Zero-length run.
    do_reset();
    push_exp("t4", 0, 0, 1'b0, 8'h00, 8'h00, 8'h00);
    start_run(16'd0);
    chk("t4_done_early", 32'(bus.done), 32'd0);
    chk("t4_busy0", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_busy1", 32'(bus.busy), 32'd0);
    @(negedge clk);

    // Gapped valids; sixth vector exceeds num_tests and carries a bad result.
    do_reset();
    push_exp("t5", 3, 0, 1'b0, 8'h00, 8'h00, 8'h00);
    start_run(16'd3);
    send(1'b1, 8'hFF, 8'h0F, 8'h0F);
    send(1'b0, 8'h12, 8'h34, 8'hEE);
    send(1'b1, 8'hAA, 8'h55, 8'h00);
    send(1'b0, 8'h56, 8'h78, 8'hEE);
    send(1'b1, 8'hF0, 8'h3C, 8'h30);
    send(1'b1, 8'h00, 8'h00, 8'hFF);
    wait_done("t5");

    // Reset mid-run after two accepts (first carries a bad result).
    do_reset();
    start_run(16'd4);
    send(1'b1, 8'hFF, 8'h0F, 8'h77);
    send(1'b1, 8'hAA, 8'h55, 8'h66);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_done", 32'(bus.done), 32'd0);
    chk("t6_rst_err",  32'(bus.err),  32'd0);
    chk("t6_rst_pass", 32'(bus.pass_cnt), 32'd0);
    chk("t6_rst_fail", 32'(bus.fail_cnt), 32'd0);
    chk("t6_rst_ffy",  32'(bus.ff_y), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    push_exp("t6", 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
    start_run(16'd2);
    send(1'b1, 8'hF0, 8'h3C, 8'h30);
    send(1'b1, 8'h81, 8'h81, 8'h81);
    wait_done("t6");

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/and_stream_checker.md
Name: and_stream_checker

Overview:
- Synthesisable self-checking block for bitwise-AND datapaths; the parametrised successor to the single-bit AND pass/fail bench.
- Accepts a stream of WIDTH-bit operand pairs and computes the golden result a & b internally.
- Compares the golden result against the DUT output LATENCY cycles later and keeps pass/fail counts.
- Captures the first failing vector and reports completion after a programmed number of tests.
- Sits beside the DUT in bench or FPGA self-test wrappers.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
LATENCY, 2, DUT pipeline depth in cycles (>=1)
CNT_W, 16, width of the test-count and pass/fail counters

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; begins a test run
num_tests  input  CNT_W  number of vectors in the run; sampled on start
in_valid  input  1  a/b carry a vector this cycle
a  input  WIDTH  operand A, also driven to the DUT
b  input  WIDTH  operand B, also driven to the DUT
y_dut  input  WIDTH  DUT result, aligned LATENCY cycles after its a/b
busy  output  1  high in RUN state
done  output  1  high in DONE state
err  output  1  sticky: at least one mismatch in the current run
pass_cnt  output  CNT_W  number of matching compares
fail_cnt  output  CNT_W  number of mismatching compares
ff_a  output  WIDTH  operand A of the first failing vector
ff_b  output  WIDTH  operand B of the first failing vector
ff_y  output  WIDTH  DUT result of the first failing vector

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; busy, done, err = 0; pass_cnt, fail_cnt = 0; ff_a, ff_b, ff_y = 0; all delay-line valid bits = 0; internal issue_cnt = 0; internal tests_reg = 0.
- Reset has priority over every other input, including mid-run; in-flight vectors are discarded.

FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch num_tests into tests_reg.
  - Clear pass_cnt, fail_cnt, err, ff_*, issue_cnt, and the delay-line valids.
  - Go to RUN. If num_tests=0, go directly to DONE instead.
- RUN:
  - start is ignored.
  - Go to DONE on the cycle after the compare that makes pass_cnt+fail_cnt equal tests_reg.
- DONE:
  - done=1, and done, counters and ff_* hold.
  - start=1 behaves as it does in IDLE (restart).

Issue side:
- A vector is accepted when state=RUN, in_valid=1 and issue_cnt<tests_reg.
- On acceptance, push {1, a, b, a&b} into a LATENCY-deep shift register and increment issue_cnt.
- Otherwise push a valid=0 entry.
- in_valid outside RUN, or beyond tests_reg, is ignored.

Compare side:
- Acts on the delay-line output entry when its valid=1 and state=RUN.
- y_dut == stored expected: pass_cnt+1.
- y_dut != stored expected: fail_cnt+1 and err=1.
- If the mismatch is the first with err=0 beforehand, capture ff_a, ff_b and ff_y in the same cycle.
- Counter and flag updates are visible on the cycle after the compare edge.
- Compare latency: a vector accepted at edge N is compared against y_dut sampled at edge N+LATENCY.
- Back-to-back vectors are supported at one per cycle; gaps in in_valid propagate as bubbles.

Counters and arithmetic:
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Comparison covers all WIDTH bits; there is no masking.

Test Plan:
- Reset, WIDTH=8, LATENCY=2; DUT is a correct 2-stage AND; start with num_tests=4; vectors (FF,0F),(AA,55),(F0,3C),(81,81) back-to-back -> pass_cnt=4, fail_cnt=0, err=0; done rises 7 cycles after the first accept (4 vectors issued, compares at edges N+2..N+5, DONE state one edge later, flags visible the following cycle); busy low.
- Same vectors, but DUT forces y=31 on the third vector (expected 30) -> fail_cnt=1, pass_cnt=3, err=1, ff_a=F0, ff_b=3C, ff_y=31.
- Two mismatches: on vector 2 (y=01) and vector 4 (y=00) -> fail_cnt=2; ff_* holds vector 2 (AA,55,01).
- num_tests=0 start -> done=1 two cycles later, counters 0, busy never asserted.
- in_valid gapped (1,0,1,0,1) with num_tests=3 and a 6th extra vector -> exactly 3 compares; the extra vector is ignored; pass_cnt=3.
- rst asserted mid-run after 2 accepts -> all outputs at reset values next cycle. A new start with num_tests=2 then gives pass_cnt=2, with no stale compares from the aborted run.
